// File: rtl/img_block_compress_if.sv
// ---------------------------------------------------------------------------
// img_block_compress_if
//   Pixel-memory and control bundle between img_block_compress and its
//   environment (image memory plus controller).
//
//   Parameter
//     IMG_LOG2      image side = 2^IMG_LOG2 pixels
//
//   Signals
//     start         one-cycle operation request
//     mode          00 gray, 01 compress, 10/11 gray then compress
//     in_pix        pixel at [row,col], combinational read (R,G,B)
//     row, col      shared read/write pixel address
//     out_we        write strobe for out_pix at [row,col]
//     out_pix       written pixel, value carried in the green byte
//     busy          operation in progress
//     gray_done     one-cycle pulse at the end of the gray pass
//     compress_done one-cycle pulse at the end of compression
//
//   Modports
//     master        environment side (drives start/mode/in_pix)
//     slave         img_block_compress side
// ---------------------------------------------------------------------------
interface img_block_compress_if #(
  parameter int IMG_LOG2 = 6
);
  logic                start;
  logic [1:0]          mode;
  logic [23:0]         in_pix;
  logic [IMG_LOG2-1:0] row;
  logic [IMG_LOG2-1:0] col;
  logic                out_we;
  logic [23:0]         out_pix;
  logic                busy;
  logic                gray_done;
  logic                compress_done;

  modport master (
    output start, mode, in_pix,
    input  row, col, out_we, out_pix, busy, gray_done, compress_done
  );

  modport slave (
    input  start, mode, in_pix,
    output row, col, out_we, out_pix, busy, gray_done, compress_done
  );
endinterface

// File: rtl/img_block_compress.sv
// ---------------------------------------------------------------------------
// img_block_compress
//   Converts a square RGB image to gray in place and/or applies two-level
//   block truncation coding: each N x N block is replaced by a low and a
//   high level chosen from the block mean, mean absolute deviation and the
//   count of pixels at or above the mean.
//
//   Parameters
//     IMG_LOG2   image side = 2^IMG_LOG2
//     BLK_LOG2   block side N = 2^BLK_LOG2 (1..3, <= IMG_LOG2), K = N*N
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        img_block_compress_if.slave (start, mode, in_pix, row, col,
//                out_we, out_pix, busy, gray_done, compress_done)
//
//   Configuration macro
//     GRAY_LUMA_EN  defined: gray = (77R + 150G + 29B) >> 8
//                   undefined: gray = (max(R,G,B) + min(R,G,B)) / 2
// ---------------------------------------------------------------------------
module img_block_compress #(
  parameter int IMG_LOG2 = 6,
  parameter int BLK_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  img_block_compress_if.slave  bus
);

  localparam int K_LOG2 = 2 * BLK_LOG2;
  localparam int ACC_W  = 8 + K_LOG2;
  localparam int CNT_W  = K_LOG2 + 1;
  localparam logic [IMG_LOG2-1:0] ADDR_ZERO = {IMG_LOG2{1'b0}};
  localparam logic [IMG_LOG2-1:0] ADDR_ONES = {IMG_LOG2{1'b1}};
  localparam logic [IMG_LOG2-1:0] ADDR_ONE  = IMG_LOG2'(1);
  // Selects the in-block part of a row/col address.
  localparam logic [IMG_LOG2-1:0] LOW_MASK  = IMG_LOG2'((1 << BLK_LOG2) - 1);
  localparam logic [CNT_W-1:0]    K_CNT     = CNT_W'(1 << K_LOG2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRAY     = 3'd1,
    BLK_SUM  = 3'd2,
    BLK_VAR  = 3'd3,
    BLK_CALC = 3'd4,
    BLK_WR   = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t              state_r;
  logic [1:0]          mode_r;
  logic [IMG_LOG2-1:0] row_r;
  logic [IMG_LOG2-1:0] col_r;
  logic                out_we_r;
  logic                busy_r;
  logic                gray_done_r;
  logic                compress_done_r;
  logic [ACC_W-1:0]    sum_r;
  logic [ACC_W-1:0]    vsum_r;
  logic [CNT_W-1:0]    beta_r;
  logic [7:0]          lm_r;
  logic [7:0]          hm_r;

  // Gray value of one RGB pixel.
  function automatic logic [7:0] gray_of(input logic [23:0] pix);
`ifdef GRAY_LUMA_EN
    logic [15:0] acc;
    acc = 16'd77  * {8'h00, pix[23:16]}
        + 16'd150 * {8'h00, pix[15:8]}
        + 16'd29  * {8'h00, pix[7:0]};
    return acc[15:8];
`else
    logic [7:0] mx;
    logic [7:0] mn;
    logic [8:0] s;
    mx = (pix[23:16] > pix[15:8]) ? pix[23:16] : pix[15:8];
    mx = (mx > pix[7:0]) ? mx : pix[7:0];
    mn = (pix[23:16] < pix[15:8]) ? pix[23:16] : pix[15:8];
    mn = (mn < pix[7:0]) ? mn : pix[7:0];
    s  = {1'b0, mx} + {1'b0, mn};
    return s[8:1];
`endif
  endfunction

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [7:0]          p_s;
  logic [7:0]          avg_s;
  logic [7:0]          var_s;
  logic [7:0]          gray_s;
  logic [7:0]          wr_val_s;
  logic [15:0]         kvar_s;
  logic [15:0]         lo_den_s;
  logic [15:0]         hi_den_s;
  logic [15:0]         lm_q_s;
  logic [15:0]         hm_q_s;
  logic [16:0]         hm_sum_s;
  logic [7:0]          lm_next_s;
  logic [7:0]          hm_next_s;
  logic                blk_end_s;
  logic                img_end_s;
  logic [IMG_LOG2-1:0] row_step_s;
  logic [IMG_LOG2-1:0] col_step_s;
  logic [IMG_LOG2-1:0] row_nb_s;
  logic [IMG_LOG2-1:0] col_nb_s;
  logic [IMG_LOG2-1:0] row_gray_s;
  logic [IMG_LOG2-1:0] col_gray_s;

  assign p_s       = bus.in_pix[15:8];
  assign avg_s     = 8'(sum_r >> K_LOG2);
  assign var_s     = 8'(vsum_r >> K_LOG2);
  assign gray_s    = gray_of(bus.in_pix);
  assign wr_val_s  = (state_r == GRAY) ? gray_s : ((p_s < avg_s) ? lm_r : hm_r);
  // K*var as a shift; denominators are 2*(K-beta) and 2*beta.
  assign kvar_s    = 16'(var_s) << K_LOG2;
  assign lo_den_s  = 16'({K_CNT - beta_r, 1'b0});
  assign hi_den_s  = 16'({beta_r, 1'b0});
  assign blk_end_s = ((row_r & LOW_MASK) == LOW_MASK) && ((col_r & LOW_MASK) == LOW_MASK);
  assign img_end_s = (row_r == ADDR_ONES) && (col_r == ADDR_ONES);

  // Raster stepping over the whole image for the gray pass.
  assign col_gray_s = col_r + ADDR_ONE;
  assign row_gray_s = (col_r == ADDR_ONES) ? (row_r + ADDR_ONE) : row_r;

  // Advance to the first pixel of the next block (block-raster order).
  assign col_nb_s = (col_r | LOW_MASK) + ADDR_ONE;
  assign row_nb_s = (col_r == ADDR_ONES) ? ((row_r | LOW_MASK) + ADDR_ONE) : (row_r & ~LOW_MASK);

  // Raster step inside the current block; the last pixel rewinds to the block origin.
  always_comb begin
    row_step_s = row_r;
    col_step_s = col_r;
    if ((col_r & LOW_MASK) == LOW_MASK) begin
      col_step_s = col_r & ~LOW_MASK;
      if ((row_r & LOW_MASK) == LOW_MASK) begin
        row_step_s = row_r & ~LOW_MASK;
      end else begin
        row_step_s = row_r + ADDR_ONE;
      end
    end else begin
      col_step_s = col_r + ADDR_ONE;
      row_step_s = row_r;
    end
  end

  // Low/high levels from the block statistics, clamped to 0..255.
  always_comb begin
    lm_q_s    = 16'h0000;
    hm_q_s    = 16'h0000;
    lm_next_s = avg_s;
    hm_next_s = avg_s;
    hm_sum_s  = 17'h00000;
    // All pixels at or above the mean: no low population, so Lm is the mean.
    if (beta_r == K_CNT) begin
      lm_q_s = 16'h0000;
    end else begin
      lm_q_s = kvar_s / lo_den_s;
    end
    // beta is at least 1 (the block maximum is >= the mean); guard anyway.
    if (beta_r == {CNT_W{1'b0}}) begin
      hm_q_s = 16'h0000;
    end else begin
      hm_q_s = kvar_s / hi_den_s;
    end
    if (lm_q_s > {8'h00, avg_s}) begin
      lm_next_s = 8'h00;
    end else begin
      lm_next_s = avg_s - lm_q_s[7:0];
    end
    hm_sum_s = {9'h000, avg_s} + {1'b0, hm_q_s};
    if (hm_sum_s > 17'd255) begin
      hm_next_s = 8'hFF;
    end else begin
      hm_next_s = hm_sum_s[7:0];
    end
  end

  // Control FSM with address generation, block accumulators and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      mode_r          <= 2'b00;
      row_r           <= ADDR_ZERO;
      col_r           <= ADDR_ZERO;
      out_we_r        <= 1'b0;
      busy_r          <= 1'b0;
      gray_done_r     <= 1'b0;
      compress_done_r <= 1'b0;
      sum_r           <= {ACC_W{1'b0}};
      vsum_r          <= {ACC_W{1'b0}};
      beta_r          <= {CNT_W{1'b0}};
      lm_r            <= 8'h00;
      hm_r            <= 8'h00;
    end else begin
      gray_done_r     <= 1'b0;
      compress_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mode_r <= bus.mode;
            busy_r <= 1'b1;
            row_r  <= ADDR_ZERO;
            col_r  <= ADDR_ZERO;
            sum_r  <= {ACC_W{1'b0}};
            vsum_r <= {ACC_W{1'b0}};
            beta_r <= {CNT_W{1'b0}};
            if (bus.mode == 2'b01) begin
              state_r  <= BLK_SUM;
              out_we_r <= 1'b0;
            end else begin
              state_r  <= GRAY;
              out_we_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        GRAY: begin
          row_r <= row_gray_s;
          col_r <= col_gray_s;
          if (img_end_s) begin
            gray_done_r <= 1'b1;
            out_we_r    <= 1'b0;
            sum_r       <= {ACC_W{1'b0}};
            vsum_r      <= {ACC_W{1'b0}};
            beta_r      <= {CNT_W{1'b0}};
            if (mode_r == 2'b00) begin
              state_r <= DONE;
            end else begin
              state_r <= BLK_SUM;
            end
          end else begin
            state_r <= GRAY;
          end
        end
        BLK_SUM: begin
          sum_r <= sum_r + ACC_W'(p_s);
          row_r <= row_step_s;
          col_r <= col_step_s;
          if (blk_end_s) begin
            state_r <= BLK_VAR;
          end else begin
            state_r <= BLK_SUM;
          end
        end
        BLK_VAR: begin
          vsum_r <= vsum_r + ACC_W'(abs_diff(p_s, avg_s));
          beta_r <= beta_r + CNT_W'(p_s >= avg_s);
          row_r  <= row_step_s;
          col_r  <= col_step_s;
          if (blk_end_s) begin
            state_r <= BLK_CALC;
          end else begin
            state_r <= BLK_VAR;
          end
        end
        BLK_CALC: begin
          lm_r     <= lm_next_s;
          hm_r     <= hm_next_s;
          out_we_r <= 1'b1;
          state_r  <= BLK_WR;
        end
        BLK_WR: begin
          if (blk_end_s) begin
            out_we_r <= 1'b0;
            row_r    <= row_nb_s;
            col_r    <= col_nb_s;
            sum_r    <= {ACC_W{1'b0}};
            vsum_r   <= {ACC_W{1'b0}};
            beta_r   <= {CNT_W{1'b0}};
            if (img_end_s) begin
              compress_done_r <= 1'b1;
              state_r         <= DONE;
            end else begin
              state_r <= BLK_SUM;
            end
          end else begin
            row_r   <= row_step_s;
            col_r   <= col_step_s;
            state_r <= BLK_WR;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          out_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.row           = row_r;
  assign bus.col           = col_r;
  assign bus.out_we        = out_we_r;
  // The written value follows the combinational read of the current address.
  assign bus.out_pix       = out_we_r ? {8'h00, wr_val_s, 8'h00} : 24'h000000;
  assign bus.busy          = busy_r;
  assign bus.gray_done     = gray_done_r;
  assign bus.compress_done = compress_done_r;

endmodule

// File: doc/img_block_compress.md
IMG_BLOCK_COMPRESS -- requirements
Module: img_block_compress

Interface
REQ-001 SHALL have parameter IMG_LOG2, default 6, meaning image side = 2^IMG_LOG2 pixels (square image).
REQ-002 SHALL have parameter BLK_LOG2, default 2, meaning block side N = 2^BLK_LOG2, with K = N*N pixels per block; legal range 1..3 and BLK_LOG2 <= IMG_LOG2.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin an operation.
REQ-006 mode  input  2  00 gray only; 01 compress only; 10 gray then compress; 11 behaves as 10.
REQ-007 in_pix  input  24  pixel at [row,col], combinational read (R 23:16, G 15:8, B 7:0).
REQ-008 row, col  output  IMG_LOG2 each  read and write pixel address.
REQ-009 out_we  output  1  write enable for out_pix at [row,col].
REQ-010 out_pix  output  24  written pixel, always {8'h00, value, 8'h00}.
REQ-011 busy  output  1  high from the cycle after an accepted start until the final done pulse.
REQ-012 gray_done, compress_done  output  1 each  one-cycle completion pulses.

Function
REQ-013 States SHALL be IDLE, GRAY, BLK_SUM, BLK_VAR, BLK_CALC, BLK_WR, DONE.
REQ-014 start in IDLE SHALL latch mode and move to GRAY (mode 00/10/11) or BLK_SUM (mode 01) on the next edge; start while busy SHALL be ignored.
REQ-015 GRAY SHALL visit one pixel per cycle in raster order, out_we=1, out_pix green = gray(in_pix); duration 2^(2*IMG_LOG2) cycles.
REQ-016 gray SHALL be floor((max(R,G,B)+min(R,G,B))/2) unless the macro in REQ-031 is defined.
REQ-017 After the last gray pixel, gray_done SHALL pulse for one cycle concurrently with entering BLK_SUM (mode 10/11) or DONE (mode 00).
REQ-018 Compression SHALL take blocks in block-raster order, pixels within a block in raster order; only in_pix[15:8] (p) is used.
REQ-019 BLK_SUM: K cycles, sum += p; avg = sum >> (2*BLK_LOG2); sum width 8+2*BLK_LOG2 bits.
REQ-020 BLK_VAR: K cycles, vsum += |p-avg|, beta += (p >= avg); var = vsum >> (2*BLK_LOG2).
REQ-021 BLK_CALC: exactly 1 cycle, Lm = avg - floor(K*var / (2*(K-beta))), Hm = avg + floor(K*var / (2*beta)), computed at full width.
REQ-022 If beta == K, Lm SHALL equal avg (no division); beta >= 1 always holds.
REQ-023 Lm and Hm SHALL saturate to 0..255.
REQ-024 BLK_WR: K cycles, out_we=1, value = Lm if p < avg else Hm.
REQ-025 Each block SHALL take exactly 3K+1 cycles; sum, vsum, and beta SHALL clear on entering BLK_SUM for each block.
REQ-026 After the last block's BLK_WR, compress_done SHALL pulse for one cycle concurrently with entering DONE.
REQ-027 DONE SHALL last one cycle, then IDLE; busy SHALL go low on entering IDLE.
REQ-028 In mode 10, the environment's memory is write-through: data written at cycle t appears on in_pix from t+1.

Reset
REQ-029 rst_n low SHALL immediately force IDLE with row=0, col=0, out_we=0, out_pix=0, busy=0, and both done pulses 0, including mid-operation; no done pulse SHALL follow an aborted run.
REQ-030 After rst_n rises, the block SHALL accept start on the first rising edge.

Configuration
REQ-031 Macro GRAY_LUMA_EN defined: gray = (77*R + 150*G + 29*B) >> 8; undefined: gray per REQ-016; GRAY timing is identical in both cases.

Verification
REQ-032 Gray, mode 00, all pixels (200,100,50) -> every write 24'h007D00 (macro undefined) or 24'h007C00 (GRAY_LUMA_EN); gray_done at cycle 4096 after start accepted; compress_done never asserted.
REQ-033 Compress, mode 01, block 0 rows 0-1 =10 and rows 2-3 =30 -> avg 20, var 10, beta 8, Lm 10, Hm 30; block writes 0x000A00/0x001E00; block length 49 cycles.
REQ-034 Uniform block p=77 -> beta=16, Lm=Hm=77, all writes 24'h004D00, no X/divide fault.
REQ-035 Block with fifteen p=255 and one p=0 -> avg 239, var 29, beta 15, Lm 7, Hm 254 (saturation check within range).
REQ-036 Mode 10, 64x64 -> gray_done at cycle 4096, compress_done at cycle 4096+256*49; start pulsed mid-run is ignored.
REQ-037 rst_n low mid-BLK_VAR -> outputs zero immediately, no done pulse; new start runs a complete operation.
